// File: rtl/m_acq_ctrl.sv
// Acquisition controller for a double-banked sample buffer: pre-trigger fill,
// edge/auto trigger, post-trigger fill, then bank hand-off to the display side.
module m_acq_ctrl #(
  parameter int          DEPTH   = 512,
  parameter logic [23:0] AUTO_TO = 24'd1000000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       ARM,
  input  logic       SINGLE,
  input  logic       AUTO,
  input  logic       TRG,
  input  logic [8:0] PRE,
  input  logic       SWAP,
  output logic       WE,
  output logic [8:0] ADDR,
  output logic       BANK,
  output logic [8:0] TRIG_ADDR,
  output logic       RDY,
  output logic       AUTO_FLAG,
  output logic [2:0] ST
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PRE   = 3'd1,
    S_ARMED = 3'd2,
    S_POST  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [8:0] ADDR_MAX = 9'(DEPTH - 1);

  state_t      state, state_d;
  logic [8:0]  pre_eff, pre_q, addr;
  logic [23:0] timeout;
  logic        trg_prev, trig_edge;
  logic        start, hit_trg, hit_auto, xfer;

  assign pre_eff   = (PRE > ADDR_MAX) ? ADDR_MAX : PRE;
  assign trig_edge = TRG & ~trg_prev;
  assign WE        = (state == S_PRE) || (state == S_ARMED) || (state == S_POST);
  assign ADDR      = addr;
  assign ST        = state;

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d  = state;
    start    = 1'b0;
    hit_trg  = 1'b0;
    hit_auto = 1'b0;
    xfer     = 1'b0;
    case (state)
      S_IDLE:  if (ARM) start = 1'b1;
      S_PRE:   if (addr == pre_q - 9'd1) state_d = S_ARMED;
      S_ARMED: begin
        if (trig_edge) begin
          hit_trg = 1'b1;
          state_d = S_POST;
        end else if (AUTO && (timeout == AUTO_TO - 24'd1)) begin
          hit_auto = 1'b1;
          state_d  = S_POST;
        end
      end
      // Last post-trigger write lands DEPTH-pre_eff slots past the trigger,
      // i.e. pre_eff slots behind it modulo DEPTH.
      S_POST:  if (addr == ((TRIG_ADDR - pre_q) & ADDR_MAX)) state_d = S_DONE;
      S_DONE: begin
        if (!RDY) begin
          xfer = 1'b1;
          if (SINGLE) state_d = S_IDLE;
          else        start   = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (start) state_d = (pre_eff != 9'd0) ? S_PRE : S_ARMED;
  end

  // NOTE: registers use non-blocking assignments and an asynchronous reset in the sensitivity list.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= S_IDLE;
    else     state <= state_d;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      addr      <= '0;
      pre_q     <= '0;
      timeout   <= '0;
      trg_prev  <= 1'b0;
      TRIG_ADDR <= '0;
      AUTO_FLAG <= 1'b0;
      BANK      <= 1'b0;
      RDY       <= 1'b0;
    end else begin
      trg_prev <= TRG;

      if (start) begin
        addr  <= '0;
        pre_q <= pre_eff;
      end else if (WE) begin
        addr <= (addr == ADDR_MAX) ? 9'd0 : addr + 9'd1;
      end

      if (start)                 timeout <= '0;
      else if (state == S_ARMED) timeout <= timeout + 24'd1;

      if (hit_trg || hit_auto) begin
        TRIG_ADDR <= addr;
        AUTO_FLAG <= hit_auto;
      end

      // A completed bank is handed over only once the display has released the previous one.
      if (xfer) begin
        BANK <= ~BANK;
        RDY  <= 1'b1;
      end else if (SWAP && RDY) begin
        RDY <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_m_acq_ctrl.sv
// Randomized bench for m_acq_ctrl; expected capture timing, trigger address and
// bank hand-off come from arithmetic on the acquisition rules.
module tb_m_acq_ctrl;

  localparam int DEPTH   = 512;
  localparam int AUTO_TO = 1000;

  logic       CLK = 1'b0;
  logic       RST, ARM, SINGLE, AUTO, TRG, SWAP;
  logic [8:0] PRE;
  logic       WE, BANK, RDY, AUTO_FLAG;
  logic [8:0] ADDR, TRIG_ADDR;
  logic [2:0] ST;

  int   total = 0;
  int   bad   = 0;
  logic bank_exp = 1'b0;

  always #5 CLK = ~CLK;

  m_acq_ctrl #(.DEPTH(DEPTH), .AUTO_TO(24'd1000)) dut (
    .CLK(CLK), .RST(RST), .ARM(ARM), .SINGLE(SINGLE), .AUTO(AUTO), .TRG(TRG),
    .PRE(PRE), .SWAP(SWAP), .WE(WE), .ADDR(ADDR), .BANK(BANK),
    .TRIG_ADDR(TRIG_ADDR), .RDY(RDY), .AUTO_FLAG(AUTO_FLAG), .ST(ST)
  );

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic arm_pulse();
    @(negedge CLK); ARM = 1'b1;
    @(negedge CLK); ARM = 1'b0;
  endtask

  task automatic swap_pulse();
    @(negedge CLK); SWAP = 1'b1;
    @(negedge CLK); SWAP = 1'b0;
  endtask

  // Observes one capture from its first PRE/ARMED cycle until DONE is visible.
  // trig_k: ARMED cycle index on which TRG rises (-1 = never);
  // fall_k: if >=0, TRG is raised in PRE and held until ARMED index fall_k.
  task automatic measure(input string tag, input int pre_v, input int trig_k,
                         input int fall_k, input bit auto_v, input bit rdy_before);
    int n_pre = 0, n_armed = 0, n_post = 0, we_err = 0, addr_err = 0, st_err = 0;
    int exp_pre, exp_armed, exp_taddr, guard = 0;
    bit is_auto, done = 0;
    logic [8:0] addr_exp = '0;
    exp_pre   = (pre_v > DEPTH - 1) ? DEPTH - 1 : pre_v;
    is_auto   = auto_v && (trig_k < 0 || trig_k >= AUTO_TO);
    exp_armed = is_auto ? AUTO_TO : trig_k + 1;
    exp_taddr = (exp_pre + exp_armed - 1) % DEPTH;
    AUTO = auto_v;
    while (!done && guard < 6000) begin
      guard++;
      if (ST == 3'd4) done = 1;
      else begin
        if (WE !== 1'b1) we_err++;
        if (ADDR !== addr_exp) addr_err++;
        addr_exp = addr_exp + 9'd1;
        case (ST)
          3'd1: begin n_pre++; TRG = (fall_k >= 0); end
          3'd2: begin
            TRG = (trig_k >= 0 && n_armed >= trig_k) || (fall_k >= 0 && n_armed < fall_k);
            n_armed++;
          end
          3'd3: n_post++;
          default: st_err++;
        endcase
        @(negedge CLK);
      end
    end
    TRG = 1'b0;
    total++; if (!done) begin bad++; $display("FAIL %s done_timeout: state=%0d want 4", tag, ST); end
    total++; if (n_pre != exp_pre) begin bad++; $display("FAIL %s pre_cycles: got %0d want %0d", tag, n_pre, exp_pre); end
    total++; if (n_armed != exp_armed) begin bad++; $display("FAIL %s armed_cycles: got %0d want %0d", tag, n_armed, exp_armed); end
    total++; if (n_post != DEPTH - exp_pre) begin bad++; $display("FAIL %s post_writes: got %0d want %0d", tag, n_post, DEPTH - exp_pre); end
    total++; if (we_err + addr_err + st_err != 0) begin bad++; $display("FAIL %s write_seq: we_err=%0d addr_err=%0d st_err=%0d want 0", tag, we_err, addr_err, st_err); end
    total++; if (TRIG_ADDR !== 9'(exp_taddr)) begin bad++; $display("FAIL %s trig_addr: got %0d want %0d", tag, TRIG_ADDR, exp_taddr); end
    total++; if (AUTO_FLAG !== is_auto) begin bad++; $display("FAIL %s auto_flag: got %0b want %0b", tag, AUTO_FLAG, is_auto); end
    total++; if (RDY !== rdy_before || BANK !== bank_exp || WE !== 1'b0) begin bad++;
      $display("FAIL %s done_entry: rdy=%0b bank=%0b we=%0b want rdy=%0b bank=%0b we=0", tag, RDY, BANK, WE, rdy_before, bank_exp); end
  endtask

  // Single-shot wrap-up: bank handed over, back to IDLE, then display releases it.
  task automatic finish_single(input string tag);
    @(negedge CLK);
    bank_exp = ~bank_exp;
    total++; if (RDY !== 1'b1 || BANK !== bank_exp || ST !== 3'd0 || WE !== 1'b0) begin bad++;
      $display("FAIL %s handoff: rdy=%0b bank=%0b st=%0d we=%0b want rdy=1 bank=%0b st=0 we=0", tag, RDY, BANK, ST, WE, bank_exp); end
    swap_pulse();
    total++; if (RDY !== 1'b0) begin bad++; $display("FAIL %s swap_clear: rdy=%0b want 0", tag, RDY); end
  endtask

  task automatic test_reset();
    RST = 1'b1; ARM = 0; SINGLE = 1; AUTO = 0; TRG = 0; SWAP = 0; PRE = '0;
    repeat (3) @(negedge CLK);
    total++; if ({ST, WE, ADDR, BANK, TRIG_ADDR, RDY, AUTO_FLAG} !== '0) begin bad++;
      $display("FAIL reset_state: st=%0d we=%0b addr=%0d bank=%0b taddr=%0d rdy=%0b af=%0b want all 0",
               ST, WE, ADDR, BANK, TRIG_ADDR, RDY, AUTO_FLAG); end
    RST = 1'b0;
    repeat (2) @(negedge CLK);
    total++; if (ST !== 3'd0 || WE !== 1'b0) begin bad++; $display("FAIL idle_no_arm: st=%0d we=%0b want 0 0", ST, WE); end
  endtask

  task automatic test_basic();
    SINGLE = 1; PRE = 9'd100;
    arm_pulse();
    measure("basic", 100, 300, -1, 0, 0);
    finish_single("basic");
    swap_pulse();
    total++; if (RDY !== 1'b0 || ST !== 3'd0 || BANK !== bank_exp) begin bad++;
      $display("FAIL swap_idle_ignored: rdy=%0b st=%0d bank=%0b want 0 0 %0b", RDY, ST, BANK, bank_exp); end
  endtask

  task automatic test_auto();
    int p;
    p = $urandom_range(0, 40);
    PRE = 9'(p); SINGLE = 1;
    arm_pulse(); measure("auto_fire", p, -1, -1, 1, 0); finish_single("auto_fire");
    arm_pulse(); measure("auto_off", p, 2500, -1, 0, 0); finish_single("auto_off");
    arm_pulse(); measure("auto_tie", p, AUTO_TO - 1, -1, 1, 0); finish_single("auto_tie");
  endtask

  task automatic test_pre_clamp();
    PRE = 9'd600 & 9'h1FF;
    PRE = 9'd511;
    arm_pulse(); measure("pre_max", 511, $urandom_range(0, 50), -1, 0, 0); finish_single("pre_max");
    PRE = 9'd0;
    arm_pulse(); measure("pre_zero", 0, $urandom_range(0, 50), -1, 0, 0); finish_single("pre_zero");
  endtask

  task automatic test_trg_held();
    PRE = 9'd50;
    arm_pulse(); measure("trg_held", 50, 30, 10, 1, 0); finish_single("trg_held");
  endtask

  task automatic test_back_to_back();
    int p, hold_err = 0;
    logic [2:0] st_start;
    p = $urandom_range(1, 200);
    PRE = 9'(p); SINGLE = 0;
    st_start = 3'd1;
    arm_pulse();
    measure("b2b_first", p, $urandom_range(0, 100), -1, 0, 0);
    @(negedge CLK);
    bank_exp = ~bank_exp;
    total++; if (RDY !== 1'b1 || BANK !== bank_exp || ST !== st_start) begin bad++;
      $display("FAIL b2b_rearm: rdy=%0b bank=%0b st=%0d want 1 %0b %0d", RDY, BANK, ST, bank_exp, st_start); end
    measure("b2b_second", p, $urandom_range(0, 100), -1, 1, 1);
    for (int i = 0; i < 20; i++) begin
      ARM = (i == 5);
      @(negedge CLK);
      if (ST !== 3'd4 || WE !== 1'b0 || BANK !== bank_exp || RDY !== 1'b1) hold_err++;
    end
    ARM = 1'b0;
    total++; if (hold_err != 0) begin bad++; $display("FAIL b2b_stall: bad_cycles=%0d want 0", hold_err); end
    swap_pulse();
    total++; if (RDY !== 1'b0 || ST !== 3'd4 || BANK !== bank_exp) begin bad++;
      $display("FAIL b2b_swap: rdy=%0b st=%0d bank=%0b want 0 4 %0b", RDY, ST, BANK, bank_exp); end
    @(negedge CLK);
    bank_exp = ~bank_exp;
    total++; if (RDY !== 1'b1 || BANK !== bank_exp || ST !== st_start) begin bad++;
      $display("FAIL b2b_transfer: rdy=%0b bank=%0b st=%0d want 1 %0b %0d", RDY, BANK, ST, bank_exp, st_start); end
    SINGLE = 1;
    measure("b2b_third", p, $urandom_range(0, 100), -1, 0, 1);
    swap_pulse();
    finish_single("b2b_third");
  endtask

  task automatic test_random();
    for (int n = 0; n < 6; n++) begin
      int p, k;
      bit a;
      p = $urandom_range(0, 700);
      k = $urandom_range(0, 1300);
      a = 1'($urandom_range(0, 1));
      PRE = 9'((p > 511) ? 511 : p);
      arm_pulse();
      measure($sformatf("rand%0d", n), p, k, -1, a, 0);
      finish_single($sformatf("rand%0d", n));
    end
  endtask

  task automatic test_reset_mid();
    int guard = 0;
    PRE = 9'd20;
    arm_pulse();
    TRG = 1'b0;
    while (ST != 3'd3 && guard < 200) begin
      TRG = (ST == 3'd2);
      @(negedge CLK); guard++;
    end
    TRG = 1'b0;
    total++; if (ST !== 3'd3) begin bad++; $display("FAIL rst_mid_reach_post: st=%0d want 3", ST); end
    repeat (5) @(negedge CLK);
    #2 RST = 1'b1;
    #1;
    bank_exp = 1'b0;
    total++; if ({ST, WE, ADDR, BANK, TRIG_ADDR, RDY, AUTO_FLAG} !== '0) begin bad++;
      $display("FAIL rst_mid_async: st=%0d we=%0b addr=%0d bank=%0b taddr=%0d rdy=%0b af=%0b want all 0",
               ST, WE, ADDR, BANK, TRIG_ADDR, RDY, AUTO_FLAG); end
    arm_pulse();
    total++; if (ST !== 3'd0 || WE !== 1'b0) begin bad++; $display("FAIL rst_held_arm: st=%0d we=%0b want 0 0", ST, WE); end
    RST = 1'b0;
    repeat (10) @(negedge CLK);
    total++; if (ST !== 3'd0 || RDY !== 1'b0 || BANK !== 1'b0) begin bad++;
      $display("FAIL rst_release_idle: st=%0d rdy=%0b bank=%0b want 0 0 0", ST, RDY, BANK); end
    arm_pulse(); measure("post_rst", 20, 5, -1, 0, 0); finish_single("post_rst");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_auto();
    test_pre_clamp();
    test_trg_held();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
